// File: rtl/decode_stage_p.sv
// rtl/decode_stage_p.sv - registered ID/EX decode stage with register file, load-use stall and flush
module decode_stage_p #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int R0_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ir_i,
  input  logic [XLEN-1:0] npc_i,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      op_o,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] npc_o,
  output logic [AW-1:0]   ri_o,
  output logic [AW-1:0]   rj_o,
  output logic [AW-1:0]   rk_o,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [5:0] OP_LW  = 6'b010000;
  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_JMP = 6'b100001;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  logic            valid_q, valid_d;
  logic [5:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, npc_q, npc_d;
  logic [AW-1:0]   ri_q, ri_d, rj_q, rj_d, rk_q, rk_d;

  logic [5:0]      dec_op;
  logic [AW-1:0]   dec_ri, dec_rj, dec_rk;
  logic [XLEN-1:0] dec_a, dec_b, dec_imm;
  logic            use_ri, use_rj, use_rk;
  logic            haz, adv;

  // An index is writable when it exists and is not the hard-wired zero register.
  function automatic logic writable(input logic [AW-1:0] idx);
    return (32'(idx) < 32'(NREG)) && !((idx == '0) && (R0_ZERO != 0));
  endfunction

  // Register read with same-cycle write-back bypass; non-writable indices read zero.
  function automatic logic [XLEN-1:0] rd(input logic [AW-1:0] idx);
    if (!writable(idx)) return '0;
    if (wb_en && (idx == wb_addr)) return wb_data;
    return regs_q[idx];
  endfunction

  // Instruction field extraction, operand selection and read-set per opcode class.
  always_comb begin
    dec_op  = ir_i[31:26];
    dec_ri  = ir_i[25:21];
    dec_rj  = ir_i[20:16];
    dec_rk  = ir_i[15:11];
    dec_a   = '0;
    dec_b   = '0;
    dec_imm = '0;
    use_ri  = 1'b0;
    use_rj  = 1'b0;
    use_rk  = 1'b0;
    if (dec_op[5:4] == 2'b00) begin
      dec_a  = rd(dec_rj);
      dec_b  = rd(dec_rk);
      use_rj = 1'b1;
      use_rk = 1'b1;
    end else if (dec_op[5:4] == 2'b01 || dec_op == OP_BEQ) begin
      // LW, SW and BEQ share operand layout; only LW does not read Ri (it writes it).
      dec_a   = rd(dec_ri);
      dec_b   = rd(dec_rj);
      dec_imm = XLEN'($signed(ir_i[15:0]));
      use_ri  = (dec_op != OP_LW);
      use_rj  = 1'b1;
    end else if (dec_op == OP_JMP) begin
      dec_imm = XLEN'(ir_i[25:0]);
    end
  end

  // Load-use hazard against the load held in ID/EX, and the handshake it gates.
  always_comb begin
    haz = in_valid && valid_q && (op_q == OP_LW) && writable(ri_q) &&
          ((use_ri && dec_ri == ri_q) || (use_rj && dec_rj == ri_q) ||
           (use_rk && dec_rk == ri_q));
    adv = out_ready || !valid_q;
    in_ready = !rst && (flush || (adv && !haz));
  end

  // Write-back into the register file, independent of stall and flush.
  always_comb begin
    regs_d = regs_q;
    if (wb_en && writable(wb_addr)) regs_d[wb_addr] = wb_data;
  end

  // ID/EX next state: flush, then bubble on hazard, then load, drain or hold.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    npc_d   = npc_q;
    ri_d    = ri_q;
    rj_d    = rj_q;
    rk_d    = rk_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv && haz) begin
      valid_d = 1'b0;
    end else if (adv && in_valid) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      a_d     = dec_a;
      b_d     = dec_b;
      imm_d   = dec_imm;
      npc_d   = npc_i;
      ri_d    = dec_ri;
      rj_d    = dec_rj;
      rk_d    = dec_rk;
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      valid_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      npc_q   <= '0;
      ri_q    <= '0;
      rj_q    <= '0;
      rk_q    <= '0;
    end else begin
      regs_q  <= regs_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      npc_q   <= npc_d;
      ri_q    <= ri_d;
      rj_q    <= rj_d;
      rk_q    <= rk_d;
    end
  end

  assign out_valid = valid_q;
  assign op_o      = op_q;
  assign a_o       = a_q;
  assign b_o       = b_q;
  assign imm_o     = imm_q;
  assign npc_o     = npc_q;
  assign ri_o      = ri_q;
  assign rj_o      = rj_q;
  assign rk_o      = rk_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// tb/tb_decode_stage_p.sv - scoreboard bench for decode_stage_p against a behavioural model
module tb_decode_stage_p;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     ir_i = '0;
  logic [XLEN-1:0] npc_i = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [5:0]      op_o;
  logic [XLEN-1:0] a_o, b_o, imm_o, npc_o;
  logic [AW-1:0]   ri_o, rj_o, rk_o;
  logic            wb_en = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;

  decode_stage_p #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ir_i(ir_i), .npc_i(npc_i), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op_o(op_o), .a_o(a_o), .b_o(b_o), .imm_o(imm_o),
    .npc_o(npc_o), .ri_o(ri_o), .rj_o(rj_o), .rk_o(rk_o),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, imm, npc;
    logic [4:0]  ri, rj, rk;
  } rec_t;

  rec_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mregs [NREG];
  bit          m_valid = 0;
  logic [5:0]  m_op = '0;
  logic [4:0]  m_ri = '0;
  bit          consumed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode class: 0 ALU, 1 LW, 2 SW, 3 BEQ, 4 JMP, 5 NOP.
  function automatic int cls(input logic [5:0] op);
    if (op < 16) return 0;
    if (op == 16) return 1;
    if (op < 32) return 2;
    if (op == 32) return 3;
    if (op == 33) return 4;
    return 5;
  endfunction

  function automatic bit m_writable(input int idx);
    return idx > 0 && idx < NREG;
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    if (!m_writable(idx)) return 32'd0;
    if (wb_en && idx == int'(wb_addr)) return wb_data;
    return mregs[idx];
  endfunction

  function automatic bit m_reads(input logic [31:0] ir, input int idx);
    int c;
    c = cls(ir[31:26]);
    case (c)
      0:       return idx == int'(ir[20:16]) || idx == int'(ir[15:11]);
      1:       return idx == int'(ir[20:16]);
      2, 3:    return idx == int'(ir[25:21]) || idx == int'(ir[20:16]);
      default: return 0;
    endcase
  endfunction

  function automatic rec_t m_decode(input logic [31:0] ir, input logic [31:0] npc);
    rec_t r;
    int c;
    r.op = ir[31:26];
    r.ri = ir[25:21];
    r.rj = ir[20:16];
    r.rk = ir[15:11];
    r.a = 0; r.b = 0; r.imm = 0; r.npc = npc;
    c = cls(r.op);
    if (c == 0) begin
      r.a = m_read(r.rj);
      r.b = m_read(r.rk);
    end else if (c >= 1 && c <= 3) begin
      r.a = m_read(r.ri);
      r.b = m_read(r.rj);
      r.imm = 32'(ir[15:0]) - (ir[15] ? 32'h0001_0000 : 32'h0);
    end else if (c == 4) begin
      r.imm = ir & 32'h03FF_FFFF;
    end
    return r;
  endfunction

  // One clock: predict and check the handshake mid-cycle, then advance the model at the edge.
  task automatic step();
    rec_t e;
    bit haz, adv, rdy;
    adv = 0; haz = 0; rdy = 0;
    @(negedge clk);
    if (rst) begin
      chk("in_ready_in_reset", in_ready, 0);
      chk("out_valid_in_reset", out_valid, 0);
    end else begin
      adv = out_ready || !m_valid;
      haz = in_valid && m_valid && m_op == 6'h10 && m_writable(m_ri) && m_reads(ir_i, m_ri);
      rdy = flush || (adv && !haz);
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, m_valid);
      e = m_decode(ir_i, npc_i);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG; i++) mregs[i] = 0;
      m_valid = 0;
      exp_q.delete();
    end else begin
      if (wb_en && m_writable(wb_addr)) mregs[wb_addr] = wb_data;
      if (flush) begin
        m_valid = 0;
        exp_q.delete();
      end else if (adv && haz) begin
        m_valid = 0;
      end else if (adv && in_valid) begin
        m_valid = 1;
        m_op = e.op;
        m_ri = e.ri;
        exp_q.push_back(e);
      end else if (adv) begin
        m_valid = 0;
      end
    end
    consumed = !rst && in_valid && rdy;
    #1;
  endtask

  // Present one instruction until accepted; returns the number of cycles it took.
  task automatic issue(input logic [31:0] ir, input logic [31:0] npc, output int cycles);
    in_valid = 1;
    ir_i = ir;
    npc_i = npc;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!consumed && cycles < 20);
    if (!consumed) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] alu(input int rj, input int rk);
    return {6'h00, 5'd0, 5'(rj), 5'(rk), 11'd0};
  endfunction

  // Monitor: every transfer to EX is compared against the oldest expected record.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got op %h expected no valid output", op_o);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("op_o", 32'(op_o), 32'(e.op));
        chk("a_o", a_o, e.a);
        chk("b_o", b_o, e.b);
        chk("imm_o", imm_o, e.imm);
        chk("npc_o", npc_o, e.npc);
        chk("ri_o", 32'(ri_o), 32'(e.ri));
        chk("rj_o", 32'(rj_o), 32'(e.rj));
        chk("rk_o", 32'(rk_o), 32'(e.rk));
      end
    end
  end

  initial begin
    int cyc;
    for (int i = 0; i < NREG; i++) mregs[i] = 0;
    step();
    step();
    chk("reset_a_o", a_o, 0);
    chk("reset_imm_o", imm_o, 0);
    chk("reset_npc_o", npc_o, 0);
    chk("reset_op_o", 32'(op_o), 0);
    rst = 0;

    wb_en = 1; wb_addr = 3; wb_data = 32'h11; step();
    wb_addr = 4; wb_data = 32'h22; step();
    wb_en = 0;
    issue(alu(3, 4), 32'h100, cyc);
    chk("alu_a", a_o, 32'h11);
    chk("alu_b", b_o, 32'h22);
    chk("alu_imm", imm_o, 0);
    chk("alu_valid", out_valid, 1);

    issue({6'h20, 5'd3, 5'd4, 16'hFFFC}, 32'h104, cyc);
    chk("beq_imm", imm_o, 32'hFFFF_FFFC);
    issue({6'h21, 26'h3FF_FFFF}, 32'h108, cyc);
    chk("jmp_imm", imm_o, 32'h03FF_FFFF);
    chk("jmp_a", a_o, 0);
    chk("jmp_b", b_o, 0);

    wb_en = 1; wb_addr = 5; wb_data = 32'hA5;
    issue(alu(5, 0), 32'h10C, cyc);
    wb_en = 0;
    chk("bypass_a", a_o, 32'hA5);
    chk("bypass_r0_b", b_o, 0);
    issue(alu(5, 3), 32'h110, cyc);
    chk("r5_later_a", a_o, 32'hA5);
    wb_en = 1; wb_addr = 0; wb_data = 32'hFF; step();
    wb_en = 0;
    issue(alu(0, 5), 32'h114, cyc);
    chk("r0_zero_a", a_o, 0);

    issue({6'h10, 5'd7, 5'd1, 16'h0004}, 32'h118, cyc);
    issue(alu(7, 3), 32'h11C, cyc);
    chk("load_use_cycles", cyc, 2);
    issue(alu(8, 3), 32'h120, cyc);
    chk("no_stall_cycles", cyc, 1);

    out_ready = 0;
    in_valid = 1; ir_i = alu(4, 3); npc_i = 32'h124;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_a", a_o, exp_q.size() != 0 ? exp_q[0].a : 32'hDEAD_BEEF);
      chk("held_in_ready", in_ready, 0);
    end
    out_ready = 1;
    flush = 1; ir_i = alu(3, 3); npc_i = 32'h128;
    step();
    flush = 0; in_valid = 0;
    chk("flush_out_valid", out_valid, 0);
    idle(1);

    wb_en = 1; wb_addr = 9; wb_data = 32'h99; step(); wb_en = 0;
    issue({6'h10, 5'd9, 5'd1, 16'h0}, 32'h12C, cyc);
    in_valid = 1; ir_i = alu(9, 1);
    step();
    rst = 1; in_valid = 0;
    step();
    chk("rst_mid_stall_valid", out_valid, 0);
    rst = 0;
    for (int r = 0; r < NREG; r += 2) begin
      issue(alu(r, r + 1), 32'h200 + 32'(r), cyc);
      chk("post_reset_a", a_o, 0);
      chk("post_reset_b", b_o, 0);
    end

    for (int n = 0; n < 1500; n++) begin
      if (!in_valid || consumed) begin
        logic [5:0] op;
        case ($urandom_range(0, 5))
          0: op = {2'b00, 4'($urandom)};
          1: op = 6'h10;
          2: op = {2'b01, 4'($urandom)};
          3: op = 6'h20;
          4: op = 6'h21;
          default: op = 6'($urandom);
        endcase
        ir_i = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'($urandom)};
        npc_i = $urandom;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      wb_en = $urandom_range(0, 1);
      wb_addr = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wb_data = $urandom;
      step();
    end
    flush = 0; wb_en = 0; out_ready = 1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
